tcam_array_model: RTL
=====================

TCAM_ARRAY_MODEL -- requirements
Module: tcam_array_model

Interface
REQ-001 Parameters: BITS 8 (entry width); WORDS 16 (entry count); ADDR_W 4 (address width); BANK 1 (bank-enable width).
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset: synchronous, active-low.
REQ-004 cs  in  1  chip select; no operation is sampled when low.
REQ-005 flush  in  1  invalidate all entries.
REQ-006 wr / rd / cmp  in  1 each  write, read and compare strobes.
REQ-007 vbe  in  1  valid-bit enable for write/read.
REQ-008 dcs  in  1  data/mask enable for write/read.
REQ-009 di  in  BITS  write data or search key.
REQ-010 mskb  in  BITS  write: stored care mask (1 = care); compare: search enable (1 = compare bit).
REQ-011 vbi  in  1  valid bit written when vbe=1.
REQ-012 a  in  ADDR_W  entry address for write/read.
REQ-013 cbe  in  BANK  bank enable, active-low; any bit 1 blocks all operations.
REQ-014 do_o  out  BITS  read data; vbo  out  1  read valid bit.
REQ-015 hit  out  1  any match; hitline  out  WORDS  per-entry match; hit_addr  out  ADDR_W  lowest matching index; multi_hit  out  1  more than one match.

Function
REQ-016 Per entry, storage SHALL hold data[BITS], care[BITS] and valid.
REQ-017 An operation SHALL be accepted only when cs=1 and cbe is all zeros.
REQ-018 Opcode priority SHALL be flush > wr > cmp > rd; lower-priority strobes asserted in the same cycle SHALL be ignored.
REQ-019 Flush SHALL clear every valid bit in one cycle and clear hit, hitline, hit_addr and multi_hit at the same edge; data and care SHALL be left unchanged.
REQ-020 Write SHALL update entry a at the sampling edge:
- dcs=1: data<=di, care<=mskb.
- vbe=1: valid<=vbi.
- Both 0: no state change.
REQ-021 Read SHALL have 1-cycle latency: do_o/vbo update at the sampling edge and are visible in the following cycle.
- do_o SHALL update only if dcs=1.
- vbo SHALL update only if vbe=1.
- Otherwise each output SHALL hold its previous value.
REQ-022 Entry i SHALL match when valid[i]=1 and, for every bit j, (mskb[j] & care[i][j])=0 or data[i][j]=di[j].
REQ-023 Compare SHALL have 1-cycle latency: hitline, hit, hit_addr and multi_hit are all registered at the sampling edge.
REQ-024 Compare outputs SHALL be held until the next compare, flush or reset.
REQ-025 hit_addr SHALL be 0 when there is no match.
REQ-026 Compare results SHALL reflect array contents before the same edge; a write at edge N SHALL be visible to a compare or read sampled at edge N+1.
REQ-027 Read-after-write to the same address on consecutive cycles SHALL return the new data.
REQ-028 When WORDS < 2**ADDR_W, out-of-range addresses SHALL behave as follows:
- Write: ignored.
- Read: do_o=0, vbo=0.
- No error output.
REQ-029 Compare with mskb all zeros SHALL match every valid entry.
REQ-030 Outputs SHALL not change during idle cycles (cs=0).

Reset
REQ-031 With rst_n=0 at an edge, the block SHALL clear every valid bit and set do_o=0, vbo=0, hit=0, hitline=0, hit_addr=0, multi_hit=0.
REQ-032 Reset SHALL leave data/care contents unspecified and need not clear them.
REQ-033 Reset SHALL override any strobe in the same cycle.
REQ-034 An operation sampled at the edge where rst_n=0 SHALL be discarded with no partial effect.
REQ-035 The first operation SHALL be accepted at the first edge with rst_n=1.

Verification
REQ-036 Write then read:
- Stimulus: write a=3, di=0xA5, mskb=0xFF, vbi=1, vbe=1, dcs=1; then read a=3 with vbe=dcs=1.
- Response: the next cycle shows do_o=0xA5, vbo=1.
REQ-037 Masked compare:
- Stimulus: entry 5 holds data=0x30, care=0xF0, valid; compare di=0x3C, mskb=0xF0.
- Response: the next cycle shows hitline=0x0020, hit=1, hit_addr=5, multi_hit=0.
REQ-038 Multi-match:
- Stimulus: entries 2 and 9 both hold 0x70/care 0xF0, valid; compare di=0x70, mskb=0xF0.
- Response: hitline=0x0204, hit_addr=2, multi_hit=1.
REQ-039 Flush:
- Stimulus: 16 valid entries, then a flush, then any compare.
- Response: hit=0, hitline=0; a read of a=0 returns vbo=0.
REQ-040 Priority:
- Stimulus: wr=1 and cmp=1 in the same cycle with a=7, di=0x11.
- Response: entry 7 is written; compare outputs are unchanged from their prior values.
REQ-041 Reset mid-operation:
- Stimulus: rst_n=0 together with wr to a=1, vbi=1.
- Response: after reset, a read of a=1 returns vbo=0 and all outputs are 0.

Source files
------------

// File: rtl/tcam_array_model_if.sv
// tcam_array_model_if: operation strobes, search/write data and result bus for the TCAM model
interface tcam_array_model_if #(
  parameter int BITS   = 8,
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4,
  parameter int BANK   = 1
);
  logic              cs, flush, wr, rd, cmp, vbe, dcs, vbi;
  logic [BITS-1:0]   di, mskb, do_o;
  logic [ADDR_W-1:0] a, hit_addr;
  logic [BANK-1:0]   cbe;
  logic              vbo, hit, multi_hit;
  logic [WORDS-1:0]  hitline;
  modport master (
    output cs, flush, wr, rd, cmp, vbe, dcs, vbi, di, mskb, a, cbe,
    input  do_o, vbo, hit, hitline, hit_addr, multi_hit
  );
  modport slave (
    input  cs, flush, wr, rd, cmp, vbe, dcs, vbi, di, mskb, a, cbe,
    output do_o, vbo, hit, hitline, hit_addr, multi_hit
  );
endinterface

// File: rtl/tcam_array_model.sv
// tcam_array_model: ternary CAM with write/read/compare/flush, registered results, priority encoded hit address
module tcam_array_model #(
  parameter int BITS   = 8,
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4,
  parameter int BANK   = 1
) (
  input logic               clk,
  input logic               rst_n,
  tcam_array_model_if.slave bus
);
  logic [BITS-1:0]   data_q [WORDS];
  logic [BITS-1:0]   care_q [WORDS];
  logic [WORDS-1:0]  valid_q, hitline_q, match_d;
  logic [BITS-1:0]   do_q;
  logic [ADDR_W-1:0] hit_addr_q, hit_addr_d;
  logic              vbo_q, hit_q, multi_hit_q, multi_hit_d;
  logic              go, do_flush, do_wr, do_cmp, do_rd, in_range;
  assign go       = rst_n && bus.cs && ~|bus.cbe;
  assign do_flush = go && bus.flush;
  assign do_wr    = go && !bus.flush && bus.wr;
  assign do_cmp   = go && !bus.flush && !bus.wr && bus.cmp;
  assign do_rd    = go && !bus.flush && !bus.wr && !bus.cmp && bus.rd;
  assign in_range = 32'(bus.a) < WORDS;
  // a bit mismatches only when the search enables it and the entry cares about it
  always_comb begin
    match_d = '0;
    for (int i = 0; i < WORDS; i++)
      match_d[i] = valid_q[i] && ((bus.mskb & care_q[i] & (data_q[i] ^ bus.di)) == '0);
  end
  always_comb begin
    hit_addr_d = '0;
    for (int i = WORDS - 1; i >= 0; i--)
      if (match_d[i]) hit_addr_d = ADDR_W'(i);
  end
  assign multi_hit_d = (match_d & (match_d - 1'b1)) != '0;
  always_ff @(posedge clk)
    if (do_wr && bus.dcs && in_range) begin
      data_q[bus.a] <= bus.di;
      care_q[bus.a] <= bus.mskb;
    end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= '0;
      do_q        <= '0;
      vbo_q       <= 1'b0;
      hitline_q   <= '0;
      hit_q       <= 1'b0;
      hit_addr_q  <= '0;
      multi_hit_q <= 1'b0;
    end else begin
      if (do_flush) begin
        valid_q     <= '0;
        hitline_q   <= '0;
        hit_q       <= 1'b0;
        hit_addr_q  <= '0;
        multi_hit_q <= 1'b0;
      end
      if (do_wr && bus.vbe && in_range) valid_q[bus.a] <= bus.vbi;
      if (do_cmp) begin
        hitline_q   <= match_d;
        hit_q       <= |match_d;
        hit_addr_q  <= hit_addr_d;
        multi_hit_q <= multi_hit_d;
      end
      if (do_rd && bus.dcs) do_q <= in_range ? data_q[bus.a] : '0;
      if (do_rd && bus.vbe) vbo_q <= in_range && valid_q[bus.a];
    end
  end
  assign bus.do_o      = do_q;
  assign bus.vbo       = vbo_q;
  assign bus.hitline   = hitline_q;
  assign bus.hit       = hit_q;
  assign bus.hit_addr  = hit_addr_q;
  assign bus.multi_hit = multi_hit_q;
endmodule
